// File: rtl/w0rm_core_pkg.sv
// Shared definitions for the W0RM core register-file scheduler.
package w0rm_core_pkg;

  // Writeback source encoding used by the round-robin arbiter.
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  // Ceiling log2; used to derive the register address width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/w0rm_core_regfile_scheduler_arb.sv
// Two-way round-robin arbiter between the ALU and memory writeback sources.
// On a tie the source not granted last wins; history moves only on accept.
module w0rm_rr_arbiter2
  import w0rm_core_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_alu_i,
  input  logic req_mem_i,
  input  logic accept_i,
  output logic gnt_alu_o,
  output logic gnt_mem_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant decode and next-state for the round-robin history.
  always_comb begin
    gnt_alu_o    = req_alu_i && (!req_mem_i || (last_grant_q == GRANT_MEM));
    gnt_mem_o    = req_mem_i && !gnt_alu_o;
    last_grant_d = last_grant_q;
    if (accept_i) begin
      last_grant_d = gnt_alu_o ? GRANT_ALU : GRANT_MEM;
    end
  end

  // History register; resets to MEM so the ALU wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GRANT_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/w0rm_core_regfile_scheduler.sv
// Write-port scheduler and destination scoreboard in front of the W0RM core
// register file. Arbitrates ALU/MEM writebacks onto the single write port,
// tracks in-flight destinations and flags read-after-write hazards.
module w0rm_core_regfile_scheduler
  import w0rm_core_pkg::*;
#(
  parameter  int DATA_WIDTH    = 32,
  parameter  int NUM_REGISTERS = 16,
  localparam int ADDR_WIDTH    = clog2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_dest_addr,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd0_hazard,
  output logic                  rd1_hazard,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  port_write_enable,
  output logic [ADDR_WIDTH-1:0] port_write_addr,
  output logic [DATA_WIDTH-1:0] port_write_data,
  output logic                  wb_unexpected
);

  logic [NUM_REGISTERS-1:0] busy_q, busy_d;
  logic                     pwe_q, pwe_d;
  logic [ADDR_WIDTH-1:0]    pwa_q, pwa_d;
  logic [DATA_WIDTH-1:0]    pwd_q, pwd_d;
  logic                     unexp_q, unexp_d;

  logic                     wb_fire;
  logic [ADDR_WIDTH-1:0]    wb_addr;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     issue_fire;

  // Ready is a pure function of valid and arbiter history, never of the scoreboard.
  w0rm_rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_alu_i (alu_valid),
    .req_mem_i (mem_valid),
    .accept_i  (wb_fire),
    .gnt_alu_o (alu_ready),
    .gnt_mem_o (mem_ready)
  );

  assign wb_fire     = alu_ready || mem_ready;
  assign wb_addr     = alu_ready ? alu_addr : mem_addr;
  assign wb_data     = alu_ready ? alu_data : mem_data;
  assign issue_ready = !busy_q[issue_dest_addr];
  assign issue_fire  = issue_valid && issue_ready;

  // Scoreboard and write-port next state: writeback clear first, then issue set.
  always_comb begin
    busy_d  = busy_q;
    pwe_d   = wb_fire;
    pwa_d   = pwa_q;
    pwd_d   = pwd_q;
    unexp_d = unexp_q;
    if (wb_fire) begin
      busy_d[wb_addr] = 1'b0;
      pwa_d           = wb_addr;
      pwd_d           = wb_data;
      if (!busy_q[wb_addr]) begin
        unexp_d = 1'b1;
      end
    end
    if (issue_fire) begin
      busy_d[issue_dest_addr] = 1'b1;
    end
  end

  // State registers; reset discards all in-flight reservations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      pwe_q   <= 1'b0;
      pwa_q   <= '0;
      pwd_q   <= '0;
      unexp_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      pwe_q   <= pwe_d;
      pwa_q   <= pwa_d;
      pwd_q   <= pwd_d;
      unexp_q <= unexp_d;
    end
  end

  assign port_write_enable = pwe_q;
  assign port_write_addr   = pwa_q;
  assign port_write_data   = pwd_q;
  assign wb_unexpected     = unexp_q;

  // Hazard also covers the cycle in which the register file commits the write.
  always_comb begin
    rd0_hazard = busy_q[rd0_addr] || (pwe_q && (pwa_q == rd0_addr));
    rd1_hazard = busy_q[rd1_addr] || (pwe_q && (pwa_q == rd1_addr));
  end

endmodule

// File: tb/tb_w0rm_core_regfile_scheduler.sv
// Directed self-checking bench for w0rm_core_regfile_scheduler.
module tb_w0rm_core_regfile_scheduler;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_dest_addr;
  logic [3:0]  rd0_addr;
  logic [3:0]  rd1_addr;
  logic        rd0_hazard;
  logic        rd1_hazard;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_addr;
  logic [31:0] mem_data;
  logic        port_write_enable;
  logic [3:0]  port_write_addr;
  logic [31:0] port_write_data;
  logic        wb_unexpected;

  int n_checks;
  int n_fail;

  logic [31:0] rf [16];

  w0rm_core_regfile_scheduler #(
    .DATA_WIDTH    (32),
    .NUM_REGISTERS (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_dest_addr   (issue_dest_addr),
    .rd0_addr          (rd0_addr),
    .rd1_addr          (rd1_addr),
    .rd0_hazard        (rd0_hazard),
    .rd1_hazard        (rd1_hazard),
    .alu_valid         (alu_valid),
    .alu_ready         (alu_ready),
    .alu_addr          (alu_addr),
    .alu_data          (alu_data),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_addr          (mem_addr),
    .mem_data          (mem_data),
    .port_write_enable (port_write_enable),
    .port_write_addr   (port_write_addr),
    .port_write_data   (port_write_data),
    .wb_unexpected     (wb_unexpected)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream register file model.
  always @(posedge clk) begin
    if (port_write_enable) rf[port_write_addr] <= port_write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_dest_addr = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #4 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rd0_addr = 4'd0; rd1_addr = 4'd15;
    #1;
    n_checks++;
    if (port_write_enable !== 1'b0 || port_write_addr !== 4'd0 || port_write_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_port: got en=%b addr=%h data=%h expected 0/0/0", port_write_enable, port_write_addr, port_write_data);
    end
    n_checks++;
    if (wb_unexpected !== 1'b0 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got unexp=%b alu_rdy=%b mem_rdy=%b expected 000", wb_unexpected, alu_ready, mem_ready);
    end
    for (int a = 0; a < 16; a++) begin
      issue_dest_addr = 4'(a);
      rd0_addr = 4'(a);
      rd1_addr = 4'(15 - a);
      #1;
      n_checks++;
      if (issue_ready !== 1'b1 || rd0_hazard !== 1'b0 || rd1_hazard !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle addr %0d: got ready=%b hz0=%b hz1=%b expected 1 0 0", a, issue_ready, rd0_hazard, rd1_hazard);
      end
    end
  endtask

  task automatic test_raw_hazard();
    issue_valid = 1'b1; issue_dest_addr = 4'd3; rd0_addr = 4'd3; rd1_addr = 4'd0;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1 || rd0_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_issue: got ready=%b hz=%b expected 1 0", issue_ready, rd0_hazard);
    end
    tick();
    issue_valid = 1'b0;
    #1;
    n_checks++;
    if (rd0_hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_busy1: got hz=%b expected 1", rd0_hazard);
    end
    tick();
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'hA5A5_0003;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0 || rd0_hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_wb: got alu_rdy=%b mem_rdy=%b hz=%b expected 1 0 1", alu_ready, mem_ready, rd0_hazard);
    end
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++;
    if (port_write_enable !== 1'b1 || port_write_addr !== 4'd3 || port_write_data !== 32'hA5A5_0003 || rd0_hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_commit: got en=%b addr=%h data=%h hz=%b expected 1 3 a5a50003 1", port_write_enable, port_write_addr, port_write_data, rd0_hazard);
    end
    tick();
    n_checks++;
    if (port_write_enable !== 1'b0 || rd0_hazard !== 1'b0 || rf[3] !== 32'hA5A5_0003 || wb_unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_done: got en=%b hz=%b rf3=%h unexp=%b expected 0 0 a5a50003 0", port_write_enable, rd0_hazard, rf[3], wb_unexpected);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  alu_tab [2];
    logic [3:0]  mem_tab [2];
    logic        exp_src [4];
    logic [3:0]  exp_addr [4];
    logic [31:0] exp_data [4];
    int ai, mi;
    alu_tab = '{4'd1, 4'd2};
    mem_tab = '{4'd5, 4'd6};
    exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_addr = '{4'd1, 4'd5, 4'd2, 4'd6};
    exp_data = '{32'hA100_0001, 32'hB200_0005, 32'hA100_0002, 32'hB200_0006};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1;
      issue_dest_addr = exp_addr[i];
      tick();
    end
    issue_valid = 1'b0;
    ai = 0; mi = 0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = (ai < 2);
      alu_addr  = (ai < 2) ? alu_tab[ai] : 4'd0;
      alu_data  = 32'hA100_0000 | 32'(alu_addr);
      mem_valid = (mi < 2);
      mem_addr  = (mi < 2) ? mem_tab[mi] : 4'd0;
      mem_data  = 32'hB200_0000 | 32'(mem_addr);
      #1;
      n_checks++;
      if (alu_ready !== !exp_src[i] || mem_ready !== exp_src[i]) begin
        n_fail++;
        $display("FAIL b2b_grant %0d: got alu_rdy=%b mem_rdy=%b expected src=%0d", i, alu_ready, mem_ready, exp_src[i]);
      end
      if (i > 0) begin
        n_checks++;
        if (port_write_enable !== 1'b1 || port_write_addr !== exp_addr[i-1] || port_write_data !== exp_data[i-1]) begin
          n_fail++;
          $display("FAIL b2b_port %0d: got en=%b addr=%h data=%h expected 1 %h %h", i - 1, port_write_enable, port_write_addr, port_write_data, exp_addr[i-1], exp_data[i-1]);
        end
      end
      tick();
      if (exp_src[i]) mi++; else ai++;
    end
    idle_inputs();
    #1;
    n_checks++;
    if (port_write_enable !== 1'b1 || port_write_addr !== exp_addr[3] || port_write_data !== exp_data[3]) begin
      n_fail++;
      $display("FAIL b2b_port 3: got en=%b addr=%h data=%h expected 1 %h %h", port_write_enable, port_write_addr, port_write_data, exp_addr[3], exp_data[3]);
    end
    tick();
    rd0_addr = 4'd1; rd1_addr = 4'd6;
    #1;
    n_checks++;
    if (port_write_enable !== 1'b0 || rd0_hazard !== 1'b0 || rd1_hazard !== 1'b0 || port_write_addr !== 4'd6) begin
      n_fail++;
      $display("FAIL b2b_done: got en=%b hz0=%b hz1=%b addr=%h expected 0 0 0 6", port_write_enable, rd0_hazard, rd1_hazard, port_write_addr);
    end
  endtask

  task automatic test_waw_stall();
    issue_valid = 1'b1; issue_dest_addr = 4'd4; rd1_addr = 4'd4;
    tick();
    #1;
    n_checks++;
    if (issue_ready !== 1'b0 || rd1_hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_stall1: got ready=%b hz=%b expected 0 1", issue_ready, rd1_hazard);
    end
    tick();
    alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 32'hCAFE_0004;
    #1;
    n_checks++;
    if (issue_ready !== 1'b0 || alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_accept_edge: got ready=%b alu_rdy=%b expected 0 1", issue_ready, alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1 || rd1_hazard !== 1'b1 || port_write_addr !== 4'd4) begin
      n_fail++;
      $display("FAIL waw_release: got ready=%b hz=%b addr=%h expected 1 1 4", issue_ready, rd1_hazard, port_write_addr);
    end
    tick();
    issue_valid = 1'b0;
    #1;
    n_checks++;
    if (issue_ready !== 1'b0 || rd1_hazard !== 1'b1 || wb_unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_reissued: got ready=%b hz=%b unexp=%b expected 0 1 0", issue_ready, rd1_hazard, wb_unexpected);
    end
    alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 32'hCAFE_1004;
    tick();
    alu_valid = 1'b0;
    tick();
    n_checks++;
    if (rd1_hazard !== 1'b0 || rf[4] !== 32'hCAFE_1004) begin
      n_fail++;
      $display("FAIL waw_drain: got hz=%b rf4=%h expected 0 cafe1004", rd1_hazard, rf[4]);
    end
  endtask

  task automatic test_unexpected();
    mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 32'h0000_1234;
    #1;
    n_checks++;
    if (mem_ready !== 1'b1 || wb_unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL unexp_pre: got mem_rdy=%b unexp=%b expected 1 0", mem_ready, wb_unexpected);
    end
    tick();
    mem_valid = 1'b0;
    #1;
    n_checks++;
    if (port_write_enable !== 1'b1 || port_write_addr !== 4'd7 || port_write_data !== 32'h0000_1234 || wb_unexpected !== 1'b1) begin
      n_fail++;
      $display("FAIL unexp_write: got en=%b addr=%h data=%h unexp=%b expected 1 7 1234 1", port_write_enable, port_write_addr, port_write_data, wb_unexpected);
    end
    tick();
    tick();
    n_checks++;
    if (wb_unexpected !== 1'b1 || rf[7] !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL unexp_sticky: got unexp=%b rf7=%h expected 1 1234", wb_unexpected, rf[7]);
    end
  endtask

  task automatic test_async_reset();
    issue_valid = 1'b1; issue_dest_addr = 4'd2; tick();
    issue_dest_addr = 4'd9; tick();
    issue_dest_addr = 4'd11; tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'd11; alu_data = 32'hDEAD_000B;
    tick();
    alu_valid = 1'b0;
    rd0_addr = 4'd2; rd1_addr = 4'd9;
    #1;
    n_checks++;
    if (port_write_enable !== 1'b1 || rd0_hazard !== 1'b1 || rd1_hazard !== 1'b1 || wb_unexpected !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got en=%b hz0=%b hz1=%b unexp=%b expected 1 1 1 1", port_write_enable, rd0_hazard, rd1_hazard, wb_unexpected);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (port_write_enable !== 1'b0 || port_write_addr !== 4'd0 || port_write_data !== 32'd0 || wb_unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_port: got en=%b addr=%h data=%h unexp=%b expected 0 0 0 0", port_write_enable, port_write_addr, port_write_data, wb_unexpected);
    end
    n_checks++;
    if (rd0_hazard !== 1'b0 || rd1_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_hazard: got hz0=%b hz1=%b expected 0 0", rd0_hazard, rd1_hazard);
    end
    #2 reset = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) begin
      issue_dest_addr = 4'(a);
      #1;
      n_checks++;
      if (issue_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL areset_busy addr %0d: got ready=%b expected 1", a, issue_ready);
      end
    end
    alu_valid = 1'b1; alu_addr = 4'd2; mem_valid = 1'b1; mem_addr = 4'd9;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_tie: got alu_rdy=%b mem_rdy=%b expected 1 0", alu_ready, mem_ready);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    reset = 1'b1;
    rd0_addr = '0;
    rd1_addr = '0;
    idle_inputs();
    #12 reset = 1'b0;
    tick();
    test_reset();
    test_raw_hazard();
    test_back_to_back();
    test_waw_stall();
    test_unexpected();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
